// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM encoding for the instruction-fetch stage.
package fetch_pkg;
    localparam int XLEN_DEFAULT = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic {S_RUN, S_FLUSH} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} with clear, count and head outputs.
module fetch_fifo #(
    parameter int W = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= push_data;
    end
    assign head = mem[rd];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one aligned imem read per cycle into a prefetch FIFO feeding decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    state_t            state, state_nx;
    logic [XLEN-1:0]   fetch_pc, inflight_pc;
    logic              inflight, issue, push, pop;
    logic [CW-1:0]     count;
    logic [XLEN+31:0]  head;
    fetch_fifo #(.W(XLEN + 32), .DEPTH(DEPTH)) fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );
    // In-flight requests reserve a slot so a response can never overflow the FIFO.
    always_comb begin
        state_nx = redirect_valid ? S_FLUSH : S_RUN;
        issue    = ~reset & ~redirect_valid & (({1'b0, count} + CW1'(inflight)) < CW1'(DEPTH));
        push     = ~reset & ~redirect_valid & inflight & (state == S_RUN);
        pop      = id_valid & id_ready;
    end
    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign id_valid    = ~reset & ~redirect_valid & (count != '0);
    assign id_instr    = id_valid ? head[31:0] : NOP_INSTR;
    assign id_pc       = id_valid ? head[XLEN+31:32] : '0;
    assign id_pc_plus4 = id_pc + XLEN'(4);
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (issue) fetch_pc <= fetch_pc + XLEN'(4);
            if (issue) inflight_pc <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, corner-case sequences and random stimulus against a queue model.
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    logic        clk, reset, imem_req, redirect_valid, id_valid, id_ready;
    logic [63:0] imem_addr, redirect_pc, id_pc, id_pc_plus4;
    logic [31:0] imem_rdata, id_instr;
    fetch_unit #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0];
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge clk) if (imem_req) imem_rdata <= word_at(imem_addr);

    int tests = 0, fails = 0;
    logic [63:0] mq[$];
    bit          pend;
    logic [63:0] pend_pc, npc;
    logic        s_req, s_valid;
    logic [63:0] s_addr, s_pc, s_plus4;
    logic [31:0] s_instr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
        bit er, ev;
        logic [63:0] epc;
        reset = rst; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        @(negedge clk);
        er  = !rst && !rv && (mq.size() + int'(pend) < DEPTH);
        ev  = !rst && !rv && (mq.size() != 0);
        epc = ev ? mq[0] : 64'h0;
        chk("imem_req", {63'h0, imem_req}, {63'h0, er});
        if (er) chk("imem_addr", imem_addr, npc);
        chk("id_valid", {63'h0, id_valid}, {63'h0, ev});
        chk("id_pc", id_pc, epc);
        chk("id_instr", {32'h0, id_instr}, {32'h0, ev ? word_at(epc) : NOP_INSTR});
        chk("id_pc_plus4", id_pc_plus4, epc + 64'd4);
        s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
        s_pc = id_pc; s_plus4 = id_pc_plus4; s_instr = id_instr;
        if (rst) begin
            mq.delete(); pend = 0; npc = RESET_PC;
        end else if (rv) begin
            mq.delete(); pend = 0; npc = {rpc[63:2], 2'b00};
        end else begin
            if (ev && rdy) void'(mq.pop_front());
            if (pend) mq.push_back(pend_pc);
            pend = er;
            if (er) begin
                pend_pc = npc;
                npc = npc + 64'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, rv, rdy, e_req, e_valid;
        logic [63:0] rpc, e_addr, e_pc;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, input logic rdy, input logic e_req, input logic [63:0] e_addr,
                       input logic e_valid, input logic [63:0] e_pc);
        vec_t v;
        v.rst = rst; v.rv = 1'b0; v.rpc = 64'h0; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0; imem_rdata = '0;
        pend = 0; pend_pc = '0; npc = RESET_PC;
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 4, 0, 0);
        add(0, 1, 1, 8, 1, 0);
        add(0, 1, 1, 12, 1, 4);
        add(0, 1, 1, 16, 1, 8);
        add(1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 4, 0, 0);
        add(0, 0, 1, 8, 1, 0);
        add(0, 0, 1, 12, 1, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 16, 1, 4);
        add(0, 1, 1, 20, 1, 8);
        add(0, 1, 1, 24, 1, 12);
        add(0, 1, 1, 28, 1, 16);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("tbl%0d_req", i), {63'h0, s_req}, {63'h0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {63'h0, s_valid}, {63'h0, tbl[i].e_valid});
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
        end
        // Redirect with three buffered entries and one request in flight.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 64'h100, 1);
        chk("redir_n_valid", {63'h0, s_valid}, 64'h0);
        step(0, 0, 0, 1);
        chk("redir_n1_addr", s_addr, 64'h100);
        chk("redir_n1_req", {63'h0, s_req}, 64'h1);
        step(0, 0, 0, 1);
        chk("redir_n2_valid", {63'h0, s_valid}, 64'h0);
        step(0, 0, 0, 1);
        chk("redir_n3_valid", {63'h0, s_valid}, 64'h1);
        chk("redir_n3_pc", s_pc, 64'h100);
        step(0, 1, 64'h203, 1);
        step(0, 0, 0, 1);
        chk("unaligned_addr", s_addr, 64'h200);
        step(0, 1, 64'h40, 1);
        step(0, 1, 64'h80, 1);
        step(0, 0, 0, 1);
        chk("b2b_addr", s_addr, 64'h80);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("b2b_pc", s_pc, 64'h80);
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        step(0, 0, 0, 1);
        chk("wrap_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_addr1", s_addr, 64'h0);
        step(0, 0, 0, 1);
        chk("wrap_pc", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_plus4", s_plus4, 64'h0);
        step(1, 1, 64'h300, 1);
        chk("rst_valid", {63'h0, s_valid}, 64'h0);
        chk("rst_instr", {32'h0, s_instr}, {32'h0, NOP_INSTR});
        step(0, 0, 0, 1);
        chk("rst_addr", s_addr, RESET_PC);
        chk("rst_req", {63'h0, s_req}, 64'h1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) == 0, $urandom_range(19) == 0,
                 {$urandom(), $urandom()}, $urandom_range(3) != 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
